// File: rtl/nx_fifo_rd_stream.sv
// nx_fifo_rd_stream: turns a FIFO read port (empty flag + head word) into a
// valid/ready stream through a two-entry holding buffer (main + skid).
// fifo_ren is registered-state based only, never combinational from out_ready.
// Optional feature macro: NX_FIFO_RD_CNT_EN enables the popped-word counter
// rd_count; when undefined rd_count is tied to zero and no counter exists.
module nx_fifo_rd_stream #(
    parameter int unsigned DATA_W = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_ren,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  rd_count
);

    // State encoding equals occupancy, so occ is the state register itself.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              pop;

    assign out_valid = (state_q != S0);
    assign out_data  = main_q;
    assign occ       = state_q;
    assign pop       = out_valid & out_ready;
    // rst_n gating keeps the FIFO untouched while reset is held.
    assign fifo_ren  = rst_n & ~fifo_empty & ~clear & (state_q != S2);

    // Buffer state and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state and buffer load decode.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (clear) begin
            state_d = S0;
        end else begin
            case (state_q)
                S0: begin
                    if (fifo_ren) begin
                        main_d  = fifo_rdata;
                        state_d = S1;
                    end
                end
                S1: begin
                    if (fifo_ren && pop) begin
                        main_d = fifo_rdata;
                    end else if (fifo_ren) begin
                        skid_d  = fifo_rdata;
                        state_d = S2;
                    end else if (pop) begin
                        state_d = S0;
                    end
                end
                S2: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = S1;
                    end
                end
                default: state_d = S0;
            endcase
        end
    end

`ifdef NX_FIFO_RD_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Popped-word counter; wraps naturally, cleared with the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign rd_count = cnt_q;
`else
    assign rd_count = '0;
`endif

endmodule

// File: tb/tb_nx_fifo_rd_stream.sv
// Self-checking bench for nx_fifo_rd_stream: a queue models the FIFO, and a
// scoreboard queue holds the words the DUT has read but not yet delivered.
module tb_nx_fifo_rd_stream;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;
`ifdef NX_FIFO_RD_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_ren;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occ;
    logic [CW-1:0] rd_count;

    nx_fifo_rd_stream #(
        .DATA_W(DW),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_ren  (fifo_ren),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ),
        .rd_count  (rd_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo_mem[$];
    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] mcnt;
    int            errors = 0;
    int            checks = 0;
    bit            c_ren, c_pop, c_clr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fifo_mem.size() == 0);
        fifo_rdata = fifo_empty ? '0 : fifo_mem[0];
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_mem.push_back(w);
        refresh();
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [CW-1:0] exp_cnt();
        return CntEn ? mcnt : '0;
    endfunction

    task automatic wait_drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (fifo_mem.size() == 0 && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask

    // Monitor: check at negedge, apply the observed transfer just after posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check_eq("fifo_ren", 32'(fifo_ren),
                         32'(!fifo_empty && !clear && exp_q.size() < 2));
                check_eq("occ", 32'(occ), 32'(exp_q.size()));
                check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) check_eq("out_data", 32'(out_data), 32'(exp_q[0]));
                check_eq("rd_count", 32'(rd_count), 32'(exp_cnt()));
                c_ren = fifo_ren;
                c_pop = out_valid && out_ready;
                c_clr = clear;
            end else begin
                c_ren = 1'b0;
                c_pop = 1'b0;
                c_clr = 1'b0;
            end
            @(posedge clk);
            #1;
            if (c_ren && fifo_mem.size() != 0) exp_q.push_back(fifo_mem.pop_front());
            if (c_clr) begin
                exp_q.delete();
                mcnt = '0;
            end else if (c_pop) begin
                void'(exp_q.pop_front());
                mcnt = mcnt + 1'b1;
            end
            refresh();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            ren_cnt;
        logic [DW-1:0] w[3];
        rst_n     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        mcnt      = '0;
        push(8'd0); push(8'd1); push(8'd0); push(8'd1);
        #1;
        // Reset state with a non-empty FIFO: no read may be issued.
        check_eq("rst_ren", 32'(fifo_ren), 32'd0);
        check_eq("rst_occ", 32'(occ), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_cnt", 32'(rd_count), 32'd0);
        step(); step();
        check_eq("rst_hold_ren", 32'(fifo_ren), 32'd0);

        // Preloaded 0,1,0,1 streamed at full rate.
        rst_n     = 1'b1;
        out_ready = 1'b1;
        ren_cnt   = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (fifo_ren) ren_cnt++;
        end
        check_eq("burst_reads", 32'(ren_cnt), 32'd4);
        wait_drain("burst_drain");
        check_eq("burst_cnt", 32'(rd_count), CntEn ? 32'd4 : 32'd0);

        // Stalled downstream: two reads fill the buffer, the third word waits.
        out_ready = 1'b0;
        w[0] = 8'hA1; w[1] = 8'hB2; w[2] = 8'hC3;
        push(w[0]); push(w[1]); push(w[2]);
        for (int i = 0; i < 4; i++) step();
        check_eq("stall_occ", 32'(occ), 32'd2);
        check_eq("stall_ren", 32'(fifo_ren), 32'd0);
        check_eq("stall_left", 32'(fifo_mem.size()), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("s2pop_ren", 32'(fifo_ren), 32'd0);
        step();
        check_eq("skid_to_main", 32'(out_data), 32'(w[1]));
        check_eq("skid_occ", 32'(occ), 32'd1);
        wait_drain("stall_drain");

        // Clear in S2 while popping.
        out_ready = 1'b0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b1;
        clear     = 1'b1;
        @(negedge clk);
        check_eq("clr_ren", 32'(fifo_ren), 32'd0);
        step();
        clear = 1'b0;
        check_eq("clr_occ", 32'(occ), 32'd0);
        check_eq("clr_valid", 32'(out_valid), 32'd0);
        check_eq("clr_cnt", 32'(rd_count), 32'd0);
        wait_drain("clr_drain");

        // Counter wrap: 17 pops from zero.
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 17; i++) push(8'(i * 7 + 3));
        wait_drain("wrap_drain");
        check_eq("wrap17", 32'(rd_count), CntEn ? 32'd1 : 32'd0);

        // Random traffic with backpressure and occasional clear.
        for (int i = 0; i < 400; i++) begin
            step();
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) != 0 && fifo_mem.size() < 8) push(8'($urandom));
        end
        clear     = 1'b0;
        out_ready = 1'b1;
        wait_drain("rand_drain");

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 6; i++) push(8'(8'h50 + i));
        step(); step();
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_occ", 32'(occ), 32'd0);
        check_eq("arst_cnt", 32'(rd_count), 32'd0);
        exp_q.delete();
        mcnt = '0;
        step();
        rst_n = 1'b1;
        wait_drain("arst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nx_fifo_rd_stream.md
NX_FIFO_RD_STREAM -- requirements
Module: nx_fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 1, FIFO read-data and stream data width.
REQ-002 SHALL have parameter CNT_W, default 16, width of the popped-word counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port fifo_empty, input, 1: the FIFO empty flag.
REQ-006 SHALL have port fifo_rdata, input, DATA_W: FIFO head word, combinationally valid while fifo_empty=0.
REQ-007 SHALL have port fifo_ren, output, 1: FIFO read enable; the FIFO pointer advances on the same edge.
REQ-008 SHALL have port clear, input, 1: synchronous flush of the holding buffer.
REQ-009 SHALL have port out_valid, output, 1: stream word available.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts the word.
REQ-011 SHALL have port out_data, output, DATA_W: stream word.
REQ-012 SHALL have port occ, output, 2: holding-buffer occupancy, 0..2.
REQ-013 SHALL have port rd_count, output, CNT_W: number of words popped downstream.

Function
REQ-014 SHALL hold words in a 2-entry buffer: main register (drives out_data) and skid register.
REQ-015 SHALL implement states S0 (occ=0), S1 (occ=1) and S2 (occ=2); out_valid=1 in S1 and S2 only.
REQ-016 SHALL define pop = out_valid & out_ready.
REQ-017 SHALL drive fifo_ren = ~fifo_empty & ~clear & (occ!=2); fifo_ren SHALL NOT depend combinationally on out_ready.
REQ-018 S0: fifo_ren captures fifo_rdata into main, next state S1; otherwise stay in S0.
REQ-019 S1: fifo_ren with pop loads main from fifo_rdata and stays S1; fifo_ren alone loads skid and moves to S2; pop alone moves to S0; neither holds.
REQ-020 S2: pop moves skid into main and goes to S1; no pop holds main and skid unchanged.
REQ-021 Data order SHALL be strict FIFO order; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 Sustained throughput SHALL be 1 word/clock while the FIFO is non-empty and out_ready=1.
REQ-023 Latency SHALL be 1 clock from fifo_ren to out_valid when starting in S0.
REQ-024 clear SHALL force S0 on the next edge regardless of pop or fifo_ren; buffered words are discarded and no FIFO read occurs that cycle.
REQ-025 rd_count SHALL increment by 1 on each pop, wrap from 2^CNT_W-1 to 0, and reset to 0 on clear.
REQ-026 SHALL never assert fifo_ren while fifo_empty=1 (no underflow generated).

Reset
REQ-027 rst_n=0 SHALL asynchronously force S0, occ=0, out_valid=0, out_data=0, skid=0, rd_count=0.
REQ-028 fifo_ren SHALL be 0 while rst_n=0; the first read SHALL occur no earlier than the first edge after rst_n deassertion.
REQ-029 Reset asserted mid-transfer SHALL drop buffered words without emitting them.

Configuration
REQ-030 Macro NX_FIFO_RD_CNT_EN defined: rd_count SHALL be implemented per REQ-025.
REQ-031 Macro NX_FIFO_RD_CNT_EN undefined: rd_count SHALL be constant 0, no counter flops SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-032 FIFO preloaded with 0,1,0,1, out_ready=1 -> fifo_ren high for 4 consecutive clocks; out_data 0,1,0,1 on consecutive cycles starting 1 clock later; rd_count=4.
REQ-033 FIFO holds 3 words, out_ready=0 -> exactly 2 reads, occ=2, fifo_ren=0 thereafter; raising out_ready -> all 3 words delivered in order.
REQ-034 In S2 with pop, fifo_empty=0 -> fifo_ren=0 that cycle, next state S1, out_data equals the former skid word.
REQ-035 clear asserted in S2 with pop=1 -> next cycle occ=0, out_valid=0, rd_count=0, no fifo_ren in the clear cycle.
REQ-036 rst_n pulsed low asynchronously mid-burst -> out_valid, occ and rd_count read 0 before the next clk edge.
REQ-037 With NX_FIFO_RD_CNT_EN and CNT_W=4, 17 pops -> rd_count=1; without the macro -> rd_count=0 throughout.
